// File: rtl/scramble_move_gen.sv
//==============================================================================
// Module      : scramble_move_gen
// Description : Pseudo-random cube scramble generator. A 32-bit LCG with
//               rejection sampling proposes face/turn candidates; accepted
//               moves are queued in a show-ahead FIFO and streamed out over a
//               valid/ready interface.
//               Optional macro SCRAMBLE_AXIS_FILTER_EN also rejects X,Y,X
//               patterns where X and Y share an axis.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module scramble_move_gen #(
    parameter logic [31:0] SEED_DEFAULT = 32'h1234_5678,
    parameter logic [31:0] LCG_A        = 32'd1664525,
    parameter logic [31:0] LCG_C        = 32'd1013904223,
    parameter int          LEN_W        = 6,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [31:0]      seed,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             move_valid,
    input  logic             move_ready,
    output logic [2:0]       move_face,
    output logic [1:0]       move_turn,
    output logic             move_last,
    output logic             busy,
    output logic             done
);

    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [LEN_W-1:0]  ONE_LEN  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]    ONE_PTR  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [2:0]        NO_FACE  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GEN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t fsm_q, fsm_d;

    logic [31:0]      lcg_q;
    logic [31:0]      lcg_next;
    logic [2:0]       cface;
    logic [1:0]       cturn;
    logic [2:0]       prev_face_q;
    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] len_q;
    logic             busy_q;
    logic             done_q;

    // FIFO storage: {face[2:0], turn[1:0], last}
    logic [5:0]       mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic             fifo_empty;
    logic             fifo_full;
    logic [5:0]       head;
    logic             pop;

    logic             gen_cycle;
    logic             axis_reject;
    logic             reject;
    logic             accept;
    logic             is_last;
    logic             start_ok;
    logic             done_set;
    logic             last_pop;

    assign lcg_next = lcg_q * LCG_A + LCG_C;
    assign cface    = lcg_q[31:29];
    assign cturn    = lcg_q[28:27];

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head       = mem[rd_ptr_q[PTR_W-1:0]];
    assign pop        = !fifo_empty && move_ready;
    assign last_pop   = pop && head[0];

    // A pop in the same cycle frees a slot, so a full FIFO does not stall then.
    assign gen_cycle  = (fsm_q == S_GEN) && (!fifo_full || pop);
    assign reject     = (cface >= 3'd6) || (cturn == 2'd3) ||
                        (cface == prev_face_q) || axis_reject;
    assign accept     = gen_cycle && !reject;
    assign is_last    = (count_q == (len_q - ONE_LEN));

`ifdef SCRAMBLE_AXIS_FILTER_EN
    logic [2:0] prev2_face_q;

    assign axis_reject = (cface[2:1] == prev_face_q[2:1]) && (prev2_face_q == cface);

    // Face two moves back, for the same-axis sandwich rule
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev2_face_q <= NO_FACE;
        end else if (start_ok) begin
            prev2_face_q <= NO_FACE;
        end else if (accept) begin
            prev2_face_q <= prev_face_q;
        end
    end
`else
    assign axis_reject = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q <= S_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM next state and control strobes
    always_comb begin
        fsm_d    = fsm_q;
        start_ok = 1'b0;
        done_set = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        start_ok = 1'b1;
                        fsm_d    = S_GEN;
                    end else begin
                        done_set = 1'b1;
                    end
                end
            end
            S_GEN: begin
                if (accept && is_last) begin
                    fsm_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_pop) begin
                    done_set = 1'b1;
                    fsm_d    = S_IDLE;
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    // LCG state: seed load wins over the per-GEN-cycle advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lcg_q <= SEED_DEFAULT;
        end else if (seed_load) begin
            lcg_q <= seed;
        end else if (gen_cycle) begin
            lcg_q <= lcg_next;
        end
    end

    // Scramble bookkeeping: length, move index, previous face
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q       <= '0;
            count_q     <= '0;
            prev_face_q <= NO_FACE;
        end else if (start_ok) begin
            len_q       <= len;
            count_q     <= '0;
            prev_face_q <= NO_FACE;
        end else if (accept) begin
            count_q     <= count_q + ONE_LEN;
            prev_face_q <= cface;
        end
    end

    // Busy spans accepted start to last pop; done is a one-cycle strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= done_set;
            if (start_ok) begin
                busy_q <= 1'b1;
            end else if (fsm_q == S_DRAIN && last_pop) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Output FIFO storage and pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                mem[wr_ptr_q[PTR_W-1:0]] <= {cface, cturn, is_last};
                wr_ptr_q <= wr_ptr_q + ONE_PTR;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ONE_PTR;
            end
        end
    end

    assign move_valid = !fifo_empty;
    assign move_face  = move_valid ? head[5:3] : 3'd0;
    assign move_turn  = move_valid ? head[2:1] : 2'd0;
    assign move_last  = move_valid ? head[0]   : 1'b0;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_scramble_move_gen.sv
//==============================================================================
// Module      : tb_scramble_move_gen
// Description : Directed self-checking bench for scramble_move_gen.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_scramble_move_gen;

    localparam int          LEN_W = 6;
    localparam logic [31:0] A     = 32'd1664525;
    localparam logic [31:0] C     = 32'd1013904223;

    logic             clk = 1'b0;
    logic             reset;
    logic             seed_load;
    logic [31:0]      seed;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             move_valid;
    logic             move_ready;
    logic [2:0]       move_face;
    logic [1:0]       move_turn;
    logic             move_last;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    logic [2:0] exp_face [64];
    logic [1:0] exp_turn [64];
    logic [2:0] got_face [64];
    int         got_n;
    int         pat_count = 0;

    scramble_move_gen dut (
        .clk        (clk),
        .reset      (reset),
        .seed_load  (seed_load),
        .seed       (seed),
        .start      (start),
        .len        (len),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .move_face  (move_face),
        .move_turn  (move_turn),
        .move_last  (move_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: LCG + rejection sampling, producing the expected move list
    task automatic build_model(input logic [31:0] sd, input int n);
        logic [31:0] s;
        logic [2:0]  cf, pf, pf2;
        logic [1:0]  ct;
        logic        rej;
        int          k;
        s = sd; pf = 3'd7; pf2 = 3'd7; k = 0;
        while (k < n) begin
            cf  = s[31:29];
            ct  = s[28:27];
            rej = (cf > 3'd5) || (ct == 2'd3) || (cf == pf);
`ifdef SCRAMBLE_AXIS_FILTER_EN
            rej = rej || (((cf >> 1) == (pf >> 1)) && (pf2 == cf));
`endif
            if (!rej) begin
                exp_face[k] = cf;
                exp_turn[k] = ct;
                pf2 = pf;
                pf  = cf;
                k++;
            end
            s = s * A + C;
        end
    endtask

    // mode 0: ready=1; 1: random ready; 2: ready=0 for 20 cycles then 1;
    // 3: ready=1 with a spurious start during GEN. stop_after>0 aborts early.
    task automatic collect(input logic [31:0] sd, input int n, input int mode, input int stop_after);
        int     k, cyc;
        logic   r, popping, finished, stopped;
        logic [2:0] pface;
        build_model(sd, n);
        got_n      = 0;
        start      = 1'b1;
        seed_load  = 1'b1;
        seed       = sd;
        len        = n[LEN_W-1:0];
        move_ready = (mode == 0 || mode == 3);
        step();
        start     = 1'b0;
        seed_load = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        k = 0; cyc = 0; finished = 1'b0; stopped = 1'b0;
        while (!finished && !stopped && cyc < 4000) begin
            start = (mode == 3 && cyc == 2);
            if (mode == 3 && cyc == 2) len = 6'd2;
            chk("no_early_done", {31'd0, done}, 32'd0);
            if (move_valid) begin
                chk("move_face",  {29'd0, move_face}, {29'd0, exp_face[k]});
                chk("move_turn",  {30'd0, move_turn}, {30'd0, exp_turn[k]});
                chk("move_last",  {31'd0, move_last}, {31'd0, (k == n - 1)});
                chk("face_range", {31'd0, (move_face <= 3'd5)}, 32'd1);
                chk("turn_range", {31'd0, (move_turn <= 2'd2)}, 32'd1);
            end
            if (mode == 2 && cyc == 19)
                chk("stall_valid", {31'd0, move_valid}, 32'd1);
            case (mode)
                1:       r = ($urandom_range(0, 1) == 1);
                2:       r = (cyc >= 20);
                default: r = 1'b1;
            endcase
            move_ready = r;
            popping    = move_valid && r;
            pface      = move_face;
            step();
            cyc++;
            if (popping) begin
                if (k > 0)
                    chk("no_repeat_face", {31'd0, (pface == got_face[k-1])}, 32'd0);
                got_face[k] = pface;
                k++;
                got_n = k;
                if (k == n) finished = 1'b1;
                if (stop_after > 0 && k == stop_after) stopped = 1'b1;
            end
        end
        start = 1'b0;
        if (!finished && !stopped) begin
            chk("collect_timeout", 32'd1, 32'd0);
        end else if (finished) begin
            chk("done_pulse",    {31'd0, done},       32'd1);
            chk("busy_fall",     {31'd0, busy},       32'd0);
            chk("valid_drained", {31'd0, move_valid}, 32'd0);
            step();
            chk("done_single",   {31'd0, done},       32'd0);
            chk("valid_idle",    {31'd0, move_valid}, 32'd0);
        end
    endtask

    initial begin
        reset      = 1'b1;
        seed_load  = 1'b0;
        seed       = '0;
        start      = 1'b0;
        len        = '0;
        move_ready = 1'b0;
        step();
        step();
        chk("rst_valid", {31'd0, move_valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy},       32'd0);
        chk("rst_done",  {31'd0, done},       32'd0);
        chk("rst_face",  {29'd0, move_face},  32'd0);
        chk("rst_turn",  {30'd0, move_turn},  32'd0);
        chk("rst_last",  {31'd0, move_last},  32'd0);
        reset = 1'b0;
        step();

        // Seed 0: the very first candidate is state 0 -> face 0, CW
        start = 1'b1; seed_load = 1'b1; seed = 32'd0; len = 6'd20; move_ready = 1'b0;
        step();
        start = 1'b0; seed_load = 1'b0;
        step();
        chk("seed0_first_valid", {31'd0, move_valid}, 32'd1);
        chk("seed0_first_face",  {29'd0, move_face},  32'd0);
        chk("seed0_first_turn",  {30'd0, move_turn},  32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();

        // Full len=20 scramble, consumer always ready
        collect(32'd0, 20, 0, 0);

        // len=63 with back-pressure
        collect(32'hDEAD_BEEF, 63, 1, 0);

        // Stalled consumer: FIFO fills, LCG holds, then the rest follows in order
        collect(32'hCAFE_0001, 10, 2, 0);

        // Zero-length scramble
        start = 1'b1; len = 6'd0;
        step();
        start = 1'b0;
        chk("len0_done",  {31'd0, done},       32'd1);
        chk("len0_busy",  {31'd0, busy},       32'd0);
        chk("len0_valid", {31'd0, move_valid}, 32'd0);
        step();
        chk("len0_done_off", {31'd0, done},       32'd0);
        chk("len0_no_valid", {31'd0, move_valid}, 32'd0);

        // Start during GEN is ignored (len stays 5)
        collect(32'h0BAD_F00D, 5, 3, 0);

        // Reset after the 5th move, then replay from move 1
        collect(32'h1357_9BDF, 20, 0, 5);
        reset = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, move_valid}, 32'd0);
        chk("midrst_busy",  {31'd0, busy},       32'd0);
        chk("midrst_done",  {31'd0, done},       32'd0);
        step();
        reset = 1'b0;
        step();
        chk("post_rst_done",  {31'd0, done},       32'd0);
        chk("post_rst_valid", {31'd0, move_valid}, 32'd0);
        collect(32'h1357_9BDF, 20, 0, 0);

        // ~10k moves: look for same-axis X,Y,X sandwiches
        for (int i = 0; i < 159; i++) begin
            collect(32'h9E37_79B9 * i + 32'd1, 63, 0, 0);
            for (int j = 2; j < got_n; j++) begin
                if (((got_face[j] >> 1) == (got_face[j-1] >> 1)) && (got_face[j-2] == got_face[j]))
                    pat_count++;
            end
        end
`ifdef SCRAMBLE_AXIS_FILTER_EN
        chk("axis_pattern_absent", pat_count, 32'd0);
`else
        chk("axis_pattern_present", {31'd0, (pat_count > 0)}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
